// File: rtl/wavetable_loader.sv
// wavetable_loader: write-side loader for the shared wavetable RAM.
// Takes a valid/ready stream of samples and writes one full table into a
// chosen bank. It refuses to start on the bank the oscillator is reading.
// Each accepted sample is followed by a dedicated write cycle, so the
// loader takes at most one sample every two cycles.
module wavetable_loader #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           bank_sel,
  input  logic [1:0]           rd_bank,
  input  logic                 abort,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [ADDRWIDTH-1:0] WADDR,
  output logic [1:0]           wbank,
  output logic [DATAWIDTH-1:0] WDATA,
  output logic                 WE,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;

  state_t                 state;
  state_t                 state_next;
  logic [ADDRWIDTH-1:0]   waddr_next;
  logic [1:0]             wbank_next;
  logic [DATAWIDTH-1:0]   wdata_next;
  logic                   err_next;

  // State and datapath registers; reset drops any load in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      WADDR <= '0;
      wbank <= '0;
      WDATA <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      WADDR <= waddr_next;
      wbank <= wbank_next;
      WDATA <= wdata_next;
      err   <= err_next;
    end
  end

  // Next-state and register-update logic; registers hold unless a transition updates them
  always_comb begin
    state_next = state;
    waddr_next = WADDR;
    wbank_next = wbank;
    wdata_next = WDATA;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        // abort is ignored here, so a simultaneous start still takes effect
        if (start) begin
          if (bank_sel != rd_bank) begin
            state_next = LOAD;
            wbank_next = bank_sel;
            waddr_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          waddr_next = '0;
        end else if (s_valid) begin
          wdata_next = s_data;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // the write strobe for this cycle is already out; abort only stops what follows
        if (abort) begin
          state_next = IDLE;
          waddr_next = '0;
        end else if (WADDR == LAST_ADDR) begin
          waddr_next = '0;
          state_next = DONE;
        end else begin
          waddr_next = WADDR + 1'b1;
          state_next = LOAD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        waddr_next = '0;
      end
    endcase
  end

  // Handshake and status flags decode from the state alone (no path from s_valid to s_ready)
  always_comb begin
    s_ready = (state == LOAD);
    WE      = (state == WRITE);
    busy    = (state == LOAD) || (state == WRITE);
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_wavetable_loader.sv
// tb_wavetable_loader: directed scoreboard bench for wavetable_loader.
// The driver pushes the expected RAM write for every sample handshake;
// a negedge monitor pops and compares on every WE cycle.
module tb_wavetable_loader;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    bank_sel;
  logic [1:0]    rd_bank;
  logic          abort;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] WADDR;
  logic [1:0]    wbank;
  logic [DW-1:0] WDATA;
  logic          WE;
  logic          busy;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [1:0]    bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            checks = 0;
  int            errors = 0;
  int            we_count = 0;
  int            done_count = 0;
  int            err_count = 0;
  int            cyc = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  logic [AW-1:0] exp_addr;
  logic [1:0]    exp_bank;

  wavetable_loader #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bank_sel (bank_sel),
    .rd_bank  (rd_bank),
    .abort    (abort),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .WADDR    (WADDR),
    .wbank    (wbank),
    .WDATA    (WDATA),
    .WE       (WE),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count rising edges so event timing can be measured in cycles
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding handshake
  always @(negedge clk) begin
    if (WE === 1'b1) begin
      we_count++;
      check_output("s_ready_low_in_write", 64'(s_ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_we: WE at WADDR=0x%0h with no pending sample", WADDR);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("we_waddr", 64'(WADDR), 64'(mon_e.addr));
        check_output("we_wbank", 64'(wbank), 64'(mon_e.bank));
        check_output("we_wdata", 64'(WDATA), 64'(mon_e.data));
      end
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if (err === 1'b1) err_count++;
  end

  // Called at a negedge: pulse start for one cycle
  task automatic send_start(input logic [1:0] bank);
    bank_sel  = bank;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at a negedge: offer one sample until it is accepted, pushing its expected write
  task automatic send_sample(input logic [DW-1:0] data, input bit gappy);
    bit ok = 1'b0;
    int tries = 0;
    while (!ok && tries < 64) begin
      s_data  = data;
      s_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (s_valid && s_ready) begin
        exp_q.push_back({exp_bank, exp_addr, data});
        exp_addr = exp_addr + 1'b1;
        ok = 1'b1;
      end
      @(negedge clk);
      tries++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL sample_timeout: sample 0x%0h not accepted, got 0 handshakes, expected 1", data);
    end
  endtask

  // Wait (bounded) until the monitor has seen the given number of done pulses
  task automatic wait_done(input int target);
    int n = 0;
    while (done_count < target && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("done_seen", 64'(done_count >= target), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check_output(name, {s_ready, WADDR, wbank, WDATA, WE, busy, done, err}, 64'd0);
  endtask

  initial begin
    int we_before;
    int done_before;
    int err_before;

    rst = 1'b1; start = 1'b0; bank_sel = 2'd0; rd_bank = 2'd0;
    abort = 1'b0; s_data = '0; s_valid = 1'b0;
    exp_addr = '0; exp_bank = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check_output("rst_s_ready", 64'(s_ready), 64'd0);
    check_output("rst_waddr",   64'(WADDR),   64'd0);
    check_output("rst_wbank",   64'(wbank),   64'd0);
    check_output("rst_wdata",   64'(WDATA),   64'd0);
    check_output("rst_we",      64'(WE),      64'd0);
    check_output("rst_busy",    64'(busy),    64'd0);
    check_output("rst_done",    64'(done),    64'd0);
    check_output("rst_err",     64'(err),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full load: bank 1, samples 0x0000..0x00FF back to back
    rd_bank = 2'd0; exp_bank = 2'd1; exp_addr = '0;
    we_before = we_count; done_before = done_count;
    send_start(2'd1);
    check_output("load_busy", 64'(busy), 64'd1);
    check_output("load_wbank", 64'(wbank), 64'd1);
    for (int i = 0; i < 256; i++) send_sample(DW'(i), 1'b0);
    s_valid = 1'b0;
    wait_done(done_before + 1);
    check_output("full_done_busy", 64'(busy), 64'd0);
    // done is high in the cycle that closes on the 513th edge after the start edge
    check_output("full_done_cycle", 64'(done_cyc - start_cyc + 1), 64'd513);
    @(negedge clk);
    check_output("full_idle_busy", 64'(busy), 64'd0);
    check_output("full_idle_waddr", 64'(WADDR), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check_output("full_we_count", 64'(we_count - we_before), 64'd256);
    check_output("full_done_count", 64'(done_count - done_before), 64'd1);

    // Bank conflict: start on the bank being read
    rd_bank = 2'd2;
    we_before = we_count; err_before = err_count;
    send_start(2'd2);
    check_output("conflict_err", 64'(err), 64'd1);
    check_output("conflict_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check_output("conflict_err_one_cycle", 64'(err), 64'd0);
    check_output("conflict_busy_after", 64'(busy), 64'd0);
    #1;
    check_output("conflict_no_we", 64'(we_count - we_before), 64'd0);
    check_output("conflict_err_count", 64'(err_count - err_before), 64'd1);

    // Load into bank 3 with random gaps, a start pulse while busy and a rd_bank change
    exp_bank = 2'd3; exp_addr = '0;
    we_before = we_count; done_before = done_count; err_before = err_count;
    send_start(2'd3);
    check_output("gap_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 256; i++) begin
      if (i == 50) rd_bank = 2'd3;
      if (i == 100) begin
        bank_sel = 2'd0;
        start = 1'b1;
      end
      send_sample(DW'(16'hA000 + i * 7), 1'b1);
      start = 1'b0;
      if (i == 101) check_output("busy_start_wbank", 64'(wbank), 64'd3);
    end
    s_valid = 1'b0;
    wait_done(done_before + 1);
    repeat (2) @(negedge clk);
    #1;
    check_output("gap_we_count", 64'(we_count - we_before), 64'd256);
    check_output("busy_start_no_err", 64'(err_count - err_before), 64'd0);
    check_output("gap_done_count", 64'(done_count - done_before), 64'd1);

    // Abort after 10 samples (last write at WADDR 9), issued in the WRITE cycle
    rd_bank = 2'd0; exp_bank = 2'd1; exp_addr = '0;
    we_before = we_count; done_before = done_count;
    send_start(2'd1);
    for (int i = 0; i < 10; i++) send_sample(DW'(16'h5500 + i), 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    s_valid = 1'b0;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_waddr", 64'(WADDR), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    check_output("abort_we_count", 64'(we_count - we_before), 64'd10);
    check_output("abort_no_done", 64'(done_count - done_before), 64'd0);

    // A new load after abort starts at WADDR 0; abort it again while in LOAD
    exp_bank = 2'd2; exp_addr = '0;
    we_before = we_count;
    send_start(2'd2);
    for (int i = 0; i < 3; i++) send_sample(DW'(16'h7700 + i), 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    check_output("reload_in_load", 64'(s_ready), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_load_busy", 64'(busy), 64'd0);
    check_output("abort_load_s_ready", 64'(s_ready), 64'd0);
    #1;
    check_output("reload_we_count", 64'(we_count - we_before), 64'd3);

    // Reset after 100 samples: everything clears and stays clear
    rd_bank = 2'd1; exp_bank = 2'd3; exp_addr = '0;
    done_before = done_count;
    send_start(2'd3);
    for (int i = 0; i < 100; i++) send_sample(DW'(16'h1234 + i), 1'b0);
    rst = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    check_all_zero("reset_outputs_zero");
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_held_zero");
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("post_reset_zero");
    end
    s_valid = 1'b0;
    #1;
    check_output("reset_no_done", 64'(done_count - done_before), 64'd0);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wavetable_loader.md
Name: wavetable_loader

Overview:
- Write-side counterpart of the wavetable oscillator's read port.
- Accepts a stream of 16-bit samples from the control side over a valid/ready handshake.
- Writes exactly one full table of 2^ADDRWIDTH entries into a selected bank of the shared wavetable RAM.
- Refuses to write the bank the oscillator is currently reading (rd_bank), so a playing table is never torn.

Parameters:
- DATAWIDTH, 16, sample width; matches the RAM data width.
- ADDRWIDTH, 8, table address width; one table is 256 entries.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to load a table into bank_sel
- bank_sel  input  2  target bank, sampled when start is accepted
- rd_bank  input  2  bank currently being read by the oscillator (its rbank)
- abort  input  1  cancels a load in progress
- s_data  input  DATAWIDTH  sample stream data
- s_valid  input  1  s_data is valid
- s_ready  output  1  loader can accept a sample this cycle
- WADDR  output  ADDRWIDTH  RAM write address
- wbank  output  2  RAM write bank
- WDATA  output  DATAWIDTH  RAM write data
- WE  output  1  RAM write strobe, one cycle per sample
- busy  output  1  a load is in progress
- done  output  1  one-cycle pulse: table complete
- err  output  1  one-cycle pulse: start rejected due to bank conflict

Behaviour:
- Reset:
  - While rst=1 at a clk edge, state=IDLE and all outputs are 0: s_ready, WADDR, wbank, WDATA, WE, busy, done, err.
  - Reset mid-load discards the load. There is no done, and no further WE.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 with bank_sel!=rd_bank: next cycle enter LOAD. wbank<=bank_sel, WADDR<=0, busy<=1.
  - start=1 with bank_sel==rd_bank: stay IDLE, err=1 for exactly the next cycle, no RAM activity.
  - start=0: stay IDLE.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready: WDATA<=s_data, then enter WRITE.
  - Without s_valid: hold LOAD indefinitely, no timeout.
- WRITE:
  - One cycle. WE=1 with the current WADDR, wbank and WDATA. s_ready=0.
  - On leaving WRITE, WDATA holds its value.
  - If WADDR==2^ADDRWIDTH-1: WADDR wraps to 0 and the next state is DONE.
  - Otherwise: WADDR increments and the next state is LOAD.
- DONE:
  - One cycle. done=1, busy=0 in the same cycle, then IDLE.
- Throughput: at most one sample per 2 cycles.
- Latency: the sample accepted at edge N is written (WE high) during the cycle after edge N.
- busy is 1 in LOAD and WRITE only.
- start while busy: ignored. No err, and bank_sel is not resampled.
- abort:
  - Honoured in LOAD or WRITE. Next state is IDLE, WADDR<=0, busy<=0, no done.
  - abort during WRITE still completes that cycle's WE (the strobe is already registered). No further writes follow.
  - abort and start in the same IDLE cycle: start wins (abort is ignored in IDLE).
- rd_bank is checked only at start. Changes to rd_bank during a load do not stop the load.
- wbank is stable from LOAD entry until the return to IDLE.
- No combinational path from s_valid to s_ready. s_ready is a function of state only.

Test Plan:
- Full load:
  - Stimulus: rd_bank=0, start with bank_sel=1, then 256 samples s_data=0x0000..0x00FF with s_valid held high.
  - Required: 256 WE pulses, each with WADDR==WDATA[7:0] and wbank=1.
  - Required: done pulses exactly once, 513 cycles after the start edge. busy=0 afterwards and WADDR=0.
- Bank conflict:
  - Stimulus: rd_bank=2, start with bank_sel=2.
  - Required: err=1 for one cycle, busy stays 0, WE never asserts.
  - Stimulus: then start with bank_sel=3.
  - Required: the load proceeds.
- Backpressure gaps:
  - Stimulus: s_valid toggles randomly.
  - Required: every written WDATA equals the sample accepted in the preceding LOAD cycle, in order.
  - Required: no WE without a prior handshake, and s_ready=0 in every WE cycle.
- Abort mid-load:
  - Stimulus: after 10 samples (last WADDR=9), assert abort.
  - Required: no WE at WADDR≥10, no done, busy=0 next cycle.
  - Required: a subsequent start writes from WADDR=0.
- Reset mid-load:
  - Stimulus: assert rst after 100 samples.
  - Required: all outputs are 0 on the next edge and stay 0 until a new start.
- Start while busy:
  - Stimulus: pulse start with a different bank_sel during the load.
  - Required: no err, wbank unchanged, 256 writes total.
